// File: rtl/qam_pkg.sv
// Shared definitions for the 2-level (BPSK-style) QAM demodulator slice:
// I-field location inside the symbol word, FSM encoding, erasure counter width.
package qam_pkg;

  localparam int I_LSB          = 0;
  localparam int I_MSB          = 11;
  localparam int I_BITS         = 12;
  localparam int ERASE_CNT_BITS = 16;

  localparam logic [ERASE_CNT_BITS-1:0] ERASE_CNT_MAX = '1;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/qam_2_demod_if.sv
// Symbol-in / word-out handshake bundle for qam_2_demod.
// master = symbol source and word sink, slave = the demodulator.
interface qam_2_demod_if #(parameter int WORD_BITS = 8);
  import qam_pkg::*;

  logic [31:0]                 sym_in;
  logic                        sym_valid;
  logic                        sym_ready;
  logic [WORD_BITS-1:0]        out_data;
  logic                        out_erasure;
  logic                        out_valid;
  logic                        out_ready;
  logic [ERASE_CNT_BITS-1:0]   erase_cnt;

  modport master (
    output sym_in, sym_valid, out_ready,
    input  sym_ready, out_data, out_erasure, out_valid, erase_cnt
  );

  modport slave (
    input  sym_in, sym_valid, out_ready,
    output sym_ready, out_data, out_erasure, out_valid, erase_cnt
  );

endinterface

// File: rtl/qam_2_slicer.sv
// Combinational hard slicer: sign of I gives the bit, small |I| flags an erasure.
// |I| is formed in I_BITS+1 bits so the most negative code (-2048) has a
// representable magnitude instead of wrapping back to itself.
module qam_2_slicer
  import qam_pkg::*;
#(
  parameter int ERASE_THR = 1
) (
  input  logic [I_BITS-1:0] i_val,
  output logic              bit_dec,
  output logic              erasure
);

  localparam logic [31:0] THR = ERASE_THR;

  logic [I_BITS:0] i_ext;
  logic [I_BITS:0] mag;

  // Sign decides the bit; magnitude below threshold marks it unreliable.
  always_comb begin
    i_ext   = {i_val[I_BITS-1], i_val};
    mag     = i_val[I_BITS-1] ? (~i_ext + 1'b1) : i_ext;
    bit_dec = i_val[I_BITS-1];
    erasure = ({{(31-I_BITS){1'b0}}, mag} < THR);
  end

endmodule

// File: rtl/qam_2_demod.sv
// Two-level demodulator: slices one symbol per accepted handshake, packs the
// decided bits LSB-first into WORD_BITS words, flags words holding any erasure,
// and keeps a saturating erasure count since reset.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_COLLECT | word filling, sym_ready=1
// ST_HOLD    | finished word presented (out_valid=1), sym_ready follows out_ready
module qam_2_demod
  import qam_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int ERASE_THR = 1
) (
  input  logic          clk,
  input  logic          rst,
  qam_2_demod_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_BITS - 1);

  state_t                      state;
  state_t                      next_state;
  logic [CNT_W-1:0]            bit_cnt;
  logic [WORD_BITS-1:0]        shift_q;
  logic [WORD_BITS-1:0]        shift_next;
  logic                        word_era_q;
  logic [WORD_BITS-1:0]        data_q;
  logic                        erasure_q;
  logic [ERASE_CNT_BITS-1:0]   ecnt_q;
  logic                        bit_dec;
  logic                        sym_era;
  logic                        accept;
  logic                        word_done;
  logic                        sym_ready_c;
  logic                        unused_sym_bits;

  // Only the I field carries information for a 2-level constellation.
  assign unused_sym_bits = ^bus.sym_in[31:I_MSB+1];

  qam_2_slicer #(.ERASE_THR(ERASE_THR)) u_slicer (
    .i_val   (bus.sym_in[I_MSB:I_LSB]),
    .bit_dec (bit_dec),
    .erasure (sym_era)
  );

  // New bit enters at the top so the first bit of a word lands in bit 0.
  assign shift_next = {bit_dec, shift_q[WORD_BITS-1:1]};
  assign accept     = bus.sym_valid && sym_ready_c;

  // Next-state and handshake decode.
  always_comb begin
    next_state  = state;
    sym_ready_c = 1'b1;
    word_done   = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (bus.sym_valid && (bit_cnt == LAST_BIT)) begin
          word_done  = 1'b1;
          next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        sym_ready_c = bus.out_ready;
        if (bus.out_ready) next_state = ST_COLLECT;
      end
      default: next_state = ST_COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_COLLECT;
    else     state <= next_state;
  end

  // Bit packer and output word register; a symbol taken in ST_HOLD starts the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      word_era_q <= 1'b0;
      data_q     <= '0;
      erasure_q  <= 1'b0;
    end else if (accept) begin
      if (word_done) begin
        data_q     <= shift_next;
        erasure_q  <= word_era_q | sym_era;
        shift_q    <= '0;
        bit_cnt    <= '0;
        word_era_q <= 1'b0;
      end else begin
        shift_q    <= shift_next;
        bit_cnt    <= bit_cnt + 1'b1;
        word_era_q <= word_era_q | sym_era;
      end
    end
  end

  // Saturating erasure counter.
  always_ff @(posedge clk) begin
    if (rst)                                          ecnt_q <= '0;
    else if (accept && sym_era && ecnt_q != ERASE_CNT_MAX) ecnt_q <= ecnt_q + 1'b1;
  end

  assign bus.sym_ready   = sym_ready_c;
  assign bus.out_data    = data_q;
  assign bus.out_erasure = erasure_q;
  assign bus.out_valid   = (state == ST_HOLD);
  assign bus.erase_cnt   = ecnt_q;

endmodule

// File: tb/tb_qam_2_demod.sv
// Directed bench for qam_2_demod (WORD_BITS=8, ERASE_THR=1): a table of
// 8-symbol words with hand-computed results, then back-pressure, reset and
// erasure-counter saturation sequences.
module tb_qam_2_demod;
  import qam_pkg::*;

  localparam int WB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qam_2_demod_if #(.WORD_BITS(WB)) bus ();

  qam_2_demod #(.WORD_BITS(WB), .ERASE_THR(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0][11:0] sym;   // sym[0] is sent first
    logic [7:0]       data;
    logic             era;
  } vec_t;

  vec_t       vecs [7];
  int         checks = 0;
  int         errors = 0;
  int         nwords = 0;
  int         ecnt_model = 0;
  logic [7:0] last_word = '0;

  // Count words actually handed downstream.
  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      nwords++;
      last_word = bus.out_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Offer one symbol for one clock; want_ready is whether it must be taken.
  task automatic send(input logic [11:0] i, input logic want_ready);
    logic [31:0] r;
    r = $urandom;
    bus.sym_in    = {r[31:12], i};
    bus.sym_valid = 1'b1;
    #1;
    chk("sym_ready", {31'd0, bus.sym_ready}, {31'd0, want_ready});
    @(posedge clk);
    #1;
    if (want_ready && i == 12'h000 && ecnt_model < 65535) ecnt_model++;
  endtask

  task automatic idle();
    bus.sym_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int w0;

  initial begin
    vecs[0] = '{sym: {12'hFFF,12'h001,12'hFFF,12'hFFF,12'h001,12'h001,12'hFFF,12'h001}, data: 8'hB2, era: 1'b0};
    vecs[1] = '{sym: {12'h001,12'h001,12'h001,12'h001,12'h000,12'h001,12'h001,12'h001}, data: 8'h00, era: 1'b1};
    vecs[2] = '{sym: {12'h001,12'h001,12'h001,12'h001,12'h001,12'h001,12'h001,12'h001}, data: 8'h00, era: 1'b0};
    vecs[3] = '{sym: {12'hFFF,12'hFFF,12'hFFF,12'hFFF,12'hFFF,12'hFFF,12'hFFF,12'hFFF}, data: 8'hFF, era: 1'b0};
    vecs[4] = '{sym: {12'h7FF,12'h7FF,12'h7FF,12'h7FF,12'h7FF,12'h7FF,12'h7FF,12'h800}, data: 8'h01, era: 1'b0};
    vecs[5] = '{sym: {12'h002,12'hFFE,12'h800,12'h7FF,12'h001,12'h000,12'hFFB,12'h005}, data: 8'h62, era: 1'b1};
    vecs[6] = '{sym: {12'hFFF,12'h001,12'h001,12'h001,12'h001,12'h001,12'h001,12'h001}, data: 8'h80, era: 1'b0};

    rst = 1'b1;
    bus.sym_in = '0;
    bus.sym_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst out_erasure", {31'd0, bus.out_erasure}, 32'd0);
    chk("rst erase_cnt", {16'd0, bus.erase_cnt}, 32'd0);
    chk("rst sym_ready", {31'd0, bus.sym_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table: words back-to-back with out_ready=1 (one symbol per clock).
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 8; k++) send(vecs[v].sym[k], 1'b1);
      chk("vec out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("vec out_data", {24'd0, bus.out_data}, {24'd0, vecs[v].data});
      chk("vec out_erasure", {31'd0, bus.out_erasure}, {31'd0, vecs[v].era});
      chk("vec erase_cnt", {16'd0, bus.erase_cnt}, ecnt_model);
    end
    idle();
    chk("vec valid drop", {31'd0, bus.out_valid}, 32'd0);
    chk("vec word count", nwords, 32'd7);
    chk("vec last word", {24'd0, last_word}, 32'h80);

    // Back-pressure: word held 5 cycles, 9th symbol waits, then becomes bit 0.
    w0 = nwords;
    for (int k = 0; k < 8; k++) send(vecs[0].sym[k], 1'b1);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      send(12'hFFF, 1'b0);
      chk("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold out_data", {24'd0, bus.out_data}, 32'hB2);
    end
    bus.out_ready = 1'b1;
    send(12'hFFF, 1'b1);
    chk("release valid drop", {31'd0, bus.out_valid}, 32'd0);
    for (int k = 0; k < 7; k++) send(12'h001, 1'b1);
    chk("next word valid", {31'd0, bus.out_valid}, 32'd1);
    chk("next word data", {24'd0, bus.out_data}, 32'h01);
    idle();
    chk("hold word count", nwords, w0 + 2);

    // Reset mid-word, with a handshake offered during reset.
    w0 = nwords;
    for (int k = 0; k < 5; k++) send(12'h001, 1'b1);
    rst = 1'b1;
    bus.sym_in = 32'h0000_0FFF;
    bus.sym_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.sym_valid = 1'b0;
    ecnt_model = 0;
    #1;
    chk("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst out_data", {24'd0, bus.out_data}, 32'd0);
    chk("midrst sym_ready", {31'd0, bus.sym_ready}, 32'd1);
    for (int k = 0; k < 8; k++) send(12'hFFF, 1'b1);
    chk("midrst word valid", {31'd0, bus.out_valid}, 32'd1);
    chk("midrst word data", {24'd0, bus.out_data}, 32'hFF);
    chk("midrst word era", {31'd0, bus.out_erasure}, 32'd0);
    idle();
    chk("midrst word count", nwords, w0 + 1);
    chk("midrst last word", {24'd0, last_word}, 32'hFF);

    // Erasure counter saturation.
    for (int k = 0; k < 65535; k++) send(12'h000, 1'b1);
    chk("sat reach", {16'd0, bus.erase_cnt}, 32'hFFFF);
    chk("sat model", {16'd0, bus.erase_cnt}, ecnt_model);
    send(12'h000, 1'b1);
    send(12'h000, 1'b1);
    chk("sat hold", {16'd0, bus.erase_cnt}, 32'hFFFF);
    // 65537 symbols so far -> one erased bit already in this word.
    send(12'h800, 1'b1);
    for (int k = 0; k < 6; k++) send(12'h001, 1'b1);
    chk("sat word valid", {31'd0, bus.out_valid}, 32'd1);
    chk("sat word data", {24'd0, bus.out_data}, 32'h02);
    chk("sat word era", {31'd0, bus.out_erasure}, 32'd1);
    chk("sat after clean", {16'd0, bus.erase_cnt}, 32'hFFFF);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qam_2_demod.md
QAM_2_DEMOD -- requirements
Module: qam_2_demod

Interface
REQ-001 Parameter: WORD_BITS, 8, number of demodulated bits packed per output word (legal 2..32).
REQ-002 Parameter: ERASE_THR, 1, minimum |I| for a confident decision; |I| < ERASE_THR marks the bit as an erasure.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: sym_in  input  32  symbol word; I = sym_in[11:0] signed 12-bit; all other bits ignored.
REQ-006 Port: sym_valid  input  1  sym_in valid this cycle.
REQ-007 Port: sym_ready  output  1  block accepts sym_in this cycle.
REQ-008 Port: out_data  output  WORD_BITS  packed decided bits.
REQ-009 Port: out_erasure  output  1  at least one bit in out_data was an erasure.
REQ-010 Port: out_valid  output  1  out_data/out_erasure valid.
REQ-011 Port: out_ready  input  1  downstream accepts the output word.
REQ-012 Port: erase_cnt  output  16  saturating count of erasures since reset.

Function
REQ-013 Symbol accepted iff sym_valid && sym_ready on a rising clk edge.
REQ-014 Bit decision: I >= 0 -> 0; I < 0 -> 1 (so 0x00000001 -> 0, 0x00000FFF -> 1).
REQ-015 Erasure: |I| < ERASE_THR; |I| computed in 13 bits (|-2048| = 2048, no overflow); bit still decided per REQ-014.
REQ-016 Packing LSB-first: first accepted bit of a word -> out_data[0], last -> out_data[WORD_BITS-1].
REQ-017 States: COLLECT (word filling) and HOLD (word presented, out_valid=1).
REQ-018 COLLECT: sym_ready=1; per accepted symbol, shift in bit, OR erasure into word flag, increment bit counter.
REQ-019 COLLECT -> HOLD on acceptance of bit WORD_BITS-1; out_data, out_erasure, out_valid=1 registered the same edge; counter and word flag cleared.
REQ-020 Latency: out_valid rises on the clk edge that accepts the last bit (visible the following cycle).
REQ-021 HOLD: out_data/out_erasure stable while out_valid=1 && out_ready=0; sym_ready = out_ready.
REQ-022 HOLD with out_ready=1, sym_valid=0: out_valid cleared, -> COLLECT.
REQ-023 HOLD with out_ready=1, sym_valid=1: output consumed and symbol accepted as bit 0 of next word in the same cycle; -> COLLECT (or straight back to HOLD when WORD_BITS... n/a, WORD_BITS>=2).
REQ-024 Sustained throughput: one symbol per clk when out_ready held 1.
REQ-025 erase_cnt increments by 1 per accepted erasure symbol; saturates at 0xFFFF, never wraps.
REQ-026 sym_valid while sym_ready=0: no state change, symbol not consumed.

Reset
REQ-027 rst overrides all other activity in the same cycle, including a simultaneous handshake.
REQ-028 After rst: state COLLECT, bit counter 0, shift reg 0, out_data 0, out_erasure 0, out_valid 0, erase_cnt 0; sym_ready=1 the first cycle after rst deasserts.
REQ-029 rst mid-word or in HOLD discards partial/pending word; no output emitted for it.

Structure
REQ-030 Shared package qam_pkg holds: I field position/width (11:0, 12), state encoding, erase_cnt width.
REQ-031 One sub-module qam_2_slicer (combinational: I -> bit, erasure); the remainder (FSM, packer, counter) in qam_2_demod.

Verification
REQ-032 WORD_BITS=8, out_ready=1, symbols 1,-1,1,1,-1,-1,1,-1 (0x001/0xFFF) back-to-back -> out_data=0xB2, out_erasure=0, one out_valid pulse, sym_ready never low.
REQ-033 Same 8 symbols, out_ready=0 for 5 cycles after out_valid -> out_data held 0xB2, sym_ready=0 throughout; a 9th symbol offered is taken only in the out_ready=1 cycle and becomes bit 0 of the next word.
REQ-034 One symbol with I=0 among seven with I=+1 -> out_data=0x00, out_erasure=1, erase_cnt=1; next clean word -> out_erasure=0.
REQ-035 rst asserted after 5 accepted bits, then 8 fresh symbols all I=0xFFF -> exactly one word 0xFF; partial word never appears.
REQ-036 Preload 65535 erasures (or force), then 2 more -> erase_cnt stays 0xFFFF; I=0x800 (-2048) decides 1, no erasure.
